// File: rtl/countdown_mmss_if.sv
// Control, preset and display bundle of the mm:ss countdown timer.
// The controlling side (tick source, buttons) is the master and the timer is the slave.
interface countdown_mmss_if;
  logic       en;
  logic       load;
  logic       start;
  logic       stop;
  logic [2:0] ld_mh;
  logic [3:0] ld_ml;
  logic [2:0] ld_sh;
  logic [3:0] ld_sl;
  logic [2:0] mh;
  logic [3:0] ml;
  logic [2:0] sh;
  logic [3:0] sl;
  logic       bw;
  logic       running;
  logic       done;
  logic       alarm;

  modport master (
    output en, load, start, stop, ld_mh, ld_ml, ld_sh, ld_sl,
    input  mh, ml, sh, sl, bw, running, done, alarm
  );

  modport slave (
    input  en, load, start, stop, ld_mh, ld_ml, ld_sh, ld_sl,
    output mh, ml, sh, sl, bw, running, done, alarm
  );
endinterface

// File: rtl/countdown_mmss.sv
// BCD mm:ss countdown timer: loads a preset, counts down once per second tick, then
// holds ALARM for a fixed number of ticks.
//  state | meaning
//  IDLE  | stopped, preset may be loaded
//  RUN   | decrementing on every tick
//  PAUSE | frozen mid-count, preset may be reloaded
//  ALRM  | reached 00:00, alarm held for ALARM_TICKS ticks
module countdown_mmss #(
  parameter int unsigned ALARM_TICKS = 8
) (
  input logic clk,
  input logic rst,
  countdown_mmss_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALRM} state_t;

  localparam logic [7:0] ALARM_LOAD = 8'(ALARM_TICKS);

  state_t     state, state_nx;
  logic [2:0] mh_q, mh_nx, mh_d, ld_mh_c;
  logic [3:0] ml_q, ml_nx, ml_d, ld_ml_c;
  logic [2:0] sh_q, sh_nx, sh_d, ld_sh_c;
  logic [3:0] sl_q, sl_nx, sl_d, ld_sl_c;
  logic [7:0] cnt_q, cnt_nx;
  logic       done_q, done_nx;
  logic       is_zero, is_one;

  assign is_zero = (mh_q == 3'd0) && (ml_q == 4'd0) && (sh_q == 3'd0) && (sl_q == 4'd0);
  assign is_one  = (mh_q == 3'd0) && (ml_q == 4'd0) && (sh_q == 3'd0) && (sl_q == 4'd1);

  // Out-of-range preset digits saturate to the largest legal digit.
  assign ld_mh_c = (bus.ld_mh > 3'd5) ? 3'd5 : bus.ld_mh;
  assign ld_ml_c = (bus.ld_ml > 4'd9) ? 4'd9 : bus.ld_ml;
  assign ld_sh_c = (bus.ld_sh > 3'd5) ? 3'd5 : bus.ld_sh;
  assign ld_sl_c = (bus.ld_sl > 4'd9) ? 4'd9 : bus.ld_sl;

  always_comb begin
    mh_d = mh_q;
    ml_d = ml_q;
    sh_d = sh_q;
    sl_d = sl_q - 4'd1;
    if (sl_q == 4'd0) begin
      sl_d = 4'd9;
      if (sh_q != 3'd0) begin
        sh_d = sh_q - 3'd1;
      end else begin
        sh_d = 3'd5;
        if (ml_q != 4'd0) begin
          ml_d = ml_q - 4'd1;
        end else begin
          ml_d = 4'd9;
          mh_d = mh_q - 3'd1;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    mh_nx    = mh_q;
    ml_nx    = ml_q;
    sh_nx    = sh_q;
    sl_nx    = sl_q;
    cnt_nx   = cnt_q;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load) begin
          {mh_nx, ml_nx, sh_nx, sl_nx} = {ld_mh_c, ld_ml_c, ld_sh_c, ld_sl_c};
        end else if (bus.start && !bus.stop && !is_zero) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_nx = PAUSE;
        end else if (bus.en && !is_zero) begin
          {mh_nx, ml_nx, sh_nx, sl_nx} = {mh_d, ml_d, sh_d, sl_d};
          if (is_one) begin
            state_nx = ALRM;
            done_nx  = 1'b1;
            cnt_nx   = ALARM_LOAD;
          end
        end
      end
      PAUSE: begin
        if (bus.load) begin
          {mh_nx, ml_nx, sh_nx, sl_nx} = {ld_mh_c, ld_ml_c, ld_sh_c, ld_sl_c};
        end else if (bus.start && !bus.stop) begin
          state_nx = is_zero ? IDLE : RUN;
        end
      end
      ALRM: begin
        if (bus.load) begin
          {mh_nx, ml_nx, sh_nx, sl_nx} = {ld_mh_c, ld_ml_c, ld_sh_c, ld_sl_c};
          state_nx = IDLE;
          cnt_nx   = 8'd0;
        end else if (bus.stop) begin
          state_nx = IDLE;
          cnt_nx   = 8'd0;
        end else if (bus.en) begin
          if (cnt_q <= 8'd1) begin
            state_nx = IDLE;
            cnt_nx   = 8'd0;
          end else begin
            cnt_nx = cnt_q - 8'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mh_q   <= 3'd0;
      ml_q   <= 4'd0;
      sh_q   <= 3'd0;
      sl_q   <= 4'd0;
      cnt_q  <= 8'd0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      mh_q   <= mh_nx;
      ml_q   <= ml_nx;
      sh_q   <= sh_nx;
      sl_q   <= sl_nx;
      cnt_q  <= cnt_nx;
      done_q <= done_nx;
    end
  end

  assign bus.mh      = mh_q;
  assign bus.ml      = ml_q;
  assign bus.sh      = sh_q;
  assign bus.sl      = sl_q;
  assign bus.running = (state == RUN);
  assign bus.alarm   = (state == ALRM);
  assign bus.done    = done_q;
  assign bus.bw      = (state == RUN) && bus.en && (sh_q == 3'd0) && (sl_q == 4'd0) && !is_zero;
endmodule

// File: tb/tb_countdown_mmss.sv
// Bench for countdown_mmss: cycle-by-cycle vector table through a one-deep scoreboard
// queue, then a bounded run through a full count and alarm.
module tb_countdown_mmss;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  countdown_mmss_if bus ();

  countdown_mmss #(.ALARM_TICKS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst, load, start, stop, en;
    logic [15:0] ld;
    logic [15:0] t;
    logic        run, alm, done, bw;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  logic [15:0] cur_t;
  assign cur_t = {1'b0, bus.mh, bus.ml, 1'b0, bus.sh, bus.sl};

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, l, s, p, e, input logic [15:0] ld, input logic [15:0] t,
                     input logic run, alm, dn, b);
    vec_t v;
    v.rst = r; v.load = l; v.start = s; v.stop = p; v.en = e;
    v.ld = ld; v.t = t; v.run = run; v.alm = alm; v.done = dn; v.bw = b;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, l, s, p, e, input logic [15:0] ld);
    rst       = r;
    bus.load  = l;
    bus.start = s;
    bus.stop  = p;
    bus.en    = e;
    bus.ld_mh = ld[14:12];
    bus.ld_ml = ld[11:8];
    bus.ld_sh = ld[6:4];
    bus.ld_sl = ld[3:0];
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vec_t e;
    int   n_en;
    int   ticks;
    logic seen;

    // rst load start stop en | preset | time run alarm done bw
    add(1,0,0,0,0, 16'h0000, 16'h0000, 0,0,0,0);
    add(0,1,0,0,0, 16'h0100, 16'h0100, 0,0,0,0);
    add(0,0,1,0,0, 16'h0000, 16'h0100, 1,0,0,0);
    add(0,0,0,0,1, 16'h0000, 16'h0059, 1,0,0,1);
    add(0,0,0,0,0, 16'h0000, 16'h0059, 1,0,0,0);
    add(0,0,0,1,0, 16'h0000, 16'h0059, 0,0,0,0);
    add(0,1,0,0,0, 16'h0003, 16'h0003, 0,0,0,0);
    add(0,0,1,0,0, 16'h0000, 16'h0003, 1,0,0,0);
    add(0,0,0,0,1, 16'h0000, 16'h0002, 1,0,0,0);
    add(0,0,0,0,1, 16'h0000, 16'h0001, 1,0,0,0);
    add(0,0,0,0,1, 16'h0000, 16'h0000, 0,1,1,0);
    add(0,0,0,0,0, 16'h0000, 16'h0000, 0,1,0,0);
    for (int i = 0; i < 7; i++) add(0,0,0,0,1, 16'h0000, 16'h0000, 0,1,0,0);
    add(0,0,0,0,1, 16'h0000, 16'h0000, 0,0,0,0);
    add(0,0,1,0,0, 16'h0000, 16'h0000, 0,0,0,0);
    add(0,1,0,0,0, 16'h1000, 16'h1000, 0,0,0,0);
    add(0,0,1,0,1, 16'h0000, 16'h1000, 1,0,0,0);
    add(0,0,0,0,1, 16'h0000, 16'h0959, 1,0,0,1);
    add(0,0,0,0,1, 16'h0000, 16'h0958, 1,0,0,0);
    add(0,0,0,0,1, 16'h0000, 16'h0957, 1,0,0,0);
    add(0,0,0,0,1, 16'h0000, 16'h0956, 1,0,0,0);
    add(0,0,0,0,1, 16'h0000, 16'h0955, 1,0,0,0);
    add(0,0,0,1,0, 16'h0000, 16'h0955, 0,0,0,0);
    for (int i = 0; i < 4; i++) add(0,0,0,0,1, 16'h0000, 16'h0955, 0,0,0,0);
    add(0,0,1,0,0, 16'h0000, 16'h0955, 1,0,0,0);
    add(0,0,0,0,1, 16'h0000, 16'h0954, 1,0,0,0);
    add(0,1,0,0,0, 16'h0300, 16'h0954, 1,0,0,0);
    add(0,0,1,1,0, 16'h0000, 16'h0954, 0,0,0,0);
    add(1,0,0,0,0, 16'h0000, 16'h0000, 0,0,0,0);
    add(0,1,0,0,0, 16'h7C6F, 16'h5959, 0,0,0,0);
    add(0,0,1,1,0, 16'h0000, 16'h5959, 0,0,0,0);
    add(0,0,1,0,0, 16'h0000, 16'h5959, 1,0,0,0);
    add(0,0,0,0,1, 16'h0000, 16'h5958, 1,0,0,0);
    add(0,0,0,1,0, 16'h0000, 16'h5958, 0,0,0,0);
    add(0,1,0,0,0, 16'h0031, 16'h0031, 0,0,0,0);
    add(0,0,1,0,0, 16'h0000, 16'h0031, 1,0,0,0);
    add(0,0,0,0,1, 16'h0000, 16'h0030, 1,0,0,0);
    add(1,0,0,0,1, 16'h0000, 16'h0000, 0,0,0,0);
    add(0,1,0,0,0, 16'h0001, 16'h0001, 0,0,0,0);
    add(0,0,1,0,0, 16'h0000, 16'h0001, 1,0,0,0);
    add(0,0,0,0,1, 16'h0000, 16'h0000, 0,1,1,0);
    add(1,0,0,0,0, 16'h0000, 16'h0000, 0,0,0,0);
    add(0,1,0,0,0, 16'h0001, 16'h0001, 0,0,0,0);
    add(0,0,1,0,0, 16'h0000, 16'h0001, 1,0,0,0);
    add(0,0,0,0,1, 16'h0000, 16'h0000, 0,1,1,0);
    add(0,0,0,1,0, 16'h0000, 16'h0000, 0,0,0,0);
    add(0,1,0,0,0, 16'h0001, 16'h0001, 0,0,0,0);
    add(0,0,1,0,0, 16'h0000, 16'h0001, 1,0,0,0);
    add(0,0,0,0,1, 16'h0000, 16'h0000, 0,1,1,0);
    add(0,1,0,0,0, 16'h0245, 16'h0245, 0,0,0,0);
    add(0,0,1,0,0, 16'h0000, 16'h0245, 1,0,0,0);

    drive(1,0,0,0,0, 16'h0000);
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].load, vecs[i].start, vecs[i].stop, vecs[i].en, vecs[i].ld);
      exp_q.push_back(vecs[i]);
      #1;
      check($sformatf("bw[%0d]", i), {15'd0, bus.bw}, {15'd0, vecs[i].bw});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("time[%0d]", i),    cur_t,                e.t);
      check($sformatf("running[%0d]", i), {15'd0, bus.running}, {15'd0, e.run});
      check($sformatf("alarm[%0d]", i),   {15'd0, bus.alarm},   {15'd0, e.alm});
      check($sformatf("done[%0d]", i),    {15'd0, bus.done},    {15'd0, e.done});
    end

    // Full count from 00:10 with a tick every cycle, then the length of the alarm.
    @(negedge clk); drive(1,0,0,0,0, 16'h0000);
    @(negedge clk); drive(0,1,0,0,0, 16'h0010);
    @(negedge clk); drive(0,0,1,0,0, 16'h0000);
    n_en = 0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      drive(0,0,0,0,1, 16'h0000);
      n_en++;
      @(posedge clk);
      #1;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", {15'd0, seen}, 16'd1);
    check("done_after_ticks", 16'(n_en), 16'd10);
    ticks = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!bus.alarm) break;
      drive(0,0,0,0,1, 16'h0000);
      ticks++;
      @(posedge clk);
      #1;
    end
    check("alarm_ticks", 16'(ticks), 16'd8);
    check("alarm_end_time", cur_t, 16'h0000);
    drive(0,0,0,0,0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
